// File: rtl/sgd_top_bw_core.sv
// Bandwidth-characterisation top: consumes one epoch quota of A/B words per epoch into lane checksums
// and writes them back. Defining SGD_STATE_COUNTERS_EN enables the um_state_counters status fields.
module sgd_top_bw_core #(
    parameter int  DATA_WIDTH_IN      = 4,
    parameter int  MAX_DIMENSION_BITS = 18,
    parameter int  SLR0_ENGINE_NUM    = 0,
    parameter int  SLR1_ENGINE_NUM    = 1,
    parameter int  SLR2_ENGINE_NUM    = 0,
    localparam int ENGINE_NUM         = SLR0_ENGINE_NUM + SLR1_ENGINE_NUM + SLR2_ENGINE_NUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_um,
    input  logic [63:0]               addr_model,
    input  logic [31:0]               mini_batch_size,
    input  logic [31:0]               step_size,
    input  logic [31:0]               number_of_epochs,
    input  logic [31:0]               dimension,
    input  logic [31:0]               number_of_samples,
    input  logic [31:0]               number_of_bits,
    output logic                      um_done,
    output logic [255:0]              um_state_counters,
    input  logic [ENGINE_NUM*512-1:0] dispatch_axb_a_data,
    input  logic [ENGINE_NUM-1:0]     dispatch_axb_a_wr_en,
    output logic [ENGINE_NUM-1:0]     dispatch_axb_a_almost_full,
    input  logic [255:0]              dispatch_axb_b_data,
    input  logic                      dispatch_axb_b_wr_en,
    output logic                      dispatch_axb_b_almost_full,
    output logic                      x_data_send_back_start,
    output logic [63:0]               x_data_send_back_addr,
    output logic [31:0]               x_data_send_back_length,
    output logic [511:0]              x_data_out,
    output logic                      x_data_out_valid,
    input  logic                      x_data_out_almost_full
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WB, S_DONE} state_t;
    localparam logic [31:0] DIM_MAX = 32'((64'd1 << MAX_DIMENSION_BITS) - 64'd1);
    localparam logic [31:0] WB_LEN  = 32'((ENGINE_NUM + 1) * 64);

    state_t       state_q, state_d;
    logic         start_prev_q;
    logic [63:0]  addr_model_q, addr_model_d, rem_q, rem_d, wb_addr_q, wb_addr_d;
    logic [31:0]  epochs_q, epochs_d, epoch_q, epoch_d, qa_q, qa_d, qb_q, qb_d;
    logic [31:0]  b_used_q, b_used_d, wb_len_q, wb_len_d;
    logic [511:0] acc_a_q [ENGINE_NUM];
    logic [511:0] acc_a_d [ENGINE_NUM];
    logic [31:0]  a_used_q [ENGINE_NUM];
    logic [31:0]  a_used_d [ENGINE_NUM];
    logic [255:0] acc_b_q, acc_b_d;
    logic [7:0]   widx_q, widx_d;
    logic         um_done_q, um_done_d, start_q, start_d, valid_q, valid_d;
    logic [511:0] data_q, data_d, wb_word;

    logic [511:0] a_mem [ENGINE_NUM][64];
    logic [5:0]   a_wp_q [ENGINE_NUM];
    logic [5:0]   a_wp_d [ENGINE_NUM];
    logic [5:0]   a_rp_q [ENGINE_NUM];
    logic [5:0]   a_rp_d [ENGINE_NUM];
    logic [6:0]   a_cnt_q [ENGINE_NUM];
    logic [6:0]   a_cnt_d [ENGINE_NUM];
    logic [ENGINE_NUM-1:0] a_af_q, a_af_d, a_push, a_pop;
    logic [255:0] b_mem [16];
    logic [3:0]   b_wp_q, b_wp_d, b_rp_q, b_rp_d;
    logic [4:0]   b_cnt_q, b_cnt_d;
    logic         b_af_q, b_af_d, b_push, b_pop;

    logic [31:0]  dim_c;
    logic [63:0]  prod;
    logic         start_edge, run_start, quotas_met, unused_ok;

    assign dim_c      = (dimension > DIM_MAX) ? DIM_MAX : dimension;
    assign prod       = 64'(number_of_samples[31:3]) * 64'(dim_c[31:6]) * 64'(number_of_bits);
    assign start_edge = start_um && !start_prev_q;
    assign run_start  = start_edge && (state_q == S_IDLE || state_q == S_DONE);
    assign unused_ok  = ^{mini_batch_size, step_size, number_of_samples[2:0], dim_c[5:0],
                          32'(DATA_WIDTH_IN)};

    // FIFO bookkeeping: pops only in RUN while quota open; almost_full follows next count
    always_comb begin
        for (int e = 0; e < ENGINE_NUM; e++) begin
            a_push[e]  = dispatch_axb_a_wr_en[e] && (a_cnt_q[e] != 7'd64);
            a_pop[e]   = (state_q == S_RUN) && (a_cnt_q[e] != 7'd0) && (a_used_q[e] < qa_q);
            a_wp_d[e]  = a_wp_q[e] + 6'(a_push[e]);
            a_rp_d[e]  = a_rp_q[e] + 6'(a_pop[e]);
            a_cnt_d[e] = a_cnt_q[e] + 7'(a_push[e]) - 7'(a_pop[e]);
            a_af_d[e]  = (a_cnt_d[e] >= 7'd56);
        end
        b_push  = dispatch_axb_b_wr_en && (b_cnt_q != 5'd16);
        b_pop   = (state_q == S_RUN) && (b_cnt_q != 5'd0) && (b_used_q < qb_q);
        b_wp_d  = b_wp_q + 4'(b_push);
        b_rp_d  = b_rp_q + 4'(b_pop);
        b_cnt_d = b_cnt_q + 5'(b_push) - 5'(b_pop);
        b_af_d  = (b_cnt_d >= 5'd12);
    end

    always_comb begin
        quotas_met = (b_used_q >= qb_q);
        wb_word    = {256'd0, acc_b_q};
        for (int e = 0; e < ENGINE_NUM; e++) begin
            if (a_used_q[e] < qa_q) quotas_met = 1'b0;
            if (widx_q == 8'(e)) wb_word = acc_a_q[e];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_model_d = addr_model_q;
        epochs_d     = epochs_q;
        epoch_d      = epoch_q;
        rem_d        = rem_q;
        qa_d         = qa_q;
        qb_d         = qb_q;
        acc_a_d      = acc_a_q;
        a_used_d     = a_used_q;
        acc_b_d      = acc_b_q;
        b_used_d     = b_used_q;
        widx_d       = widx_q;
        start_d      = 1'b0;
        valid_d      = 1'b0;
        data_d       = data_q;
        wb_addr_d    = wb_addr_q;
        wb_len_d     = wb_len_q;
        for (int e = 0; e < ENGINE_NUM; e++) begin
            if (a_pop[e]) begin
                for (int j = 0; j < 16; j++)
                    acc_a_d[e][32*j +: 32] = acc_a_q[e][32*j +: 32] + a_mem[e][a_rp_q[e]][32*j +: 32];
                a_used_d[e] = a_used_q[e] + 32'd1;
            end
        end
        if (b_pop) begin
            for (int k = 0; k < 8; k++)
                acc_b_d[32*k +: 32] = acc_b_q[32*k +: 32] + b_mem[b_rp_q][32*k +: 32];
            b_used_d = b_used_q + 32'd1;
        end
        case (state_q)
            S_IDLE, S_DONE: if (run_start) begin
                addr_model_d = addr_model;
                epochs_d     = number_of_epochs;
                epoch_d      = '0;
                rem_d        = prod;
                qa_d         = '0;
                qb_d         = {3'd0, number_of_samples[31:3]};
                acc_b_d      = '0;
                b_used_d     = '0;
                for (int e = 0; e < ENGINE_NUM; e++) begin
                    acc_a_d[e]  = '0;
                    a_used_d[e] = '0;
                end
                state_d = S_LOAD;
            end
            // Quota division by repeated subtraction, one step per cycle
            S_LOAD: begin
                if (epochs_q == 32'd0) begin
                    state_d = S_DONE;
                end else if (rem_q >= 64'(ENGINE_NUM)) begin
                    rem_d = rem_q - 64'(ENGINE_NUM);
                    qa_d  = qa_q + 32'd1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: if (quotas_met) begin
                start_d   = 1'b1;
                wb_addr_d = addr_model_q + 64'(epoch_q) * 64'(WB_LEN);
                wb_len_d  = WB_LEN;
                widx_d    = '0;
                state_d   = S_WB;
            end
            S_WB: if (!x_data_out_almost_full) begin
                valid_d = 1'b1;
                data_d  = wb_word;
                widx_d  = widx_q + 8'd1;
                if (widx_q == 8'(ENGINE_NUM)) begin
                    acc_b_d  = '0;
                    b_used_d = '0;
                    for (int e = 0; e < ENGINE_NUM; e++) begin
                        acc_a_d[e]  = '0;
                        a_used_d[e] = '0;
                    end
                    epoch_d = epoch_q + 32'd1;
                    state_d = (epoch_q + 32'd1 == epochs_q) ? S_DONE : S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        um_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            addr_model_q <= '0;
            epochs_q     <= '0;
            epoch_q      <= '0;
            rem_q        <= '0;
            qa_q         <= '0;
            qb_q         <= '0;
            acc_b_q      <= '0;
            b_used_q     <= '0;
            widx_q       <= '0;
            um_done_q    <= 1'b0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            wb_addr_q    <= '0;
            wb_len_q     <= '0;
            for (int e = 0; e < ENGINE_NUM; e++) begin
                acc_a_q[e]  <= '0;
                a_used_q[e] <= '0;
                a_wp_q[e]   <= '0;
                a_rp_q[e]   <= '0;
                a_cnt_q[e]  <= '0;
            end
            a_af_q  <= '0;
            b_wp_q  <= '0;
            b_rp_q  <= '0;
            b_cnt_q <= '0;
            b_af_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_um;
            addr_model_q <= addr_model_d;
            epochs_q     <= epochs_d;
            epoch_q      <= epoch_d;
            rem_q        <= rem_d;
            qa_q         <= qa_d;
            qb_q         <= qb_d;
            acc_b_q      <= acc_b_d;
            b_used_q     <= b_used_d;
            widx_q       <= widx_d;
            um_done_q    <= um_done_d;
            start_q      <= start_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            wb_addr_q    <= wb_addr_d;
            wb_len_q     <= wb_len_d;
            acc_a_q      <= acc_a_d;
            a_used_q     <= a_used_d;
            a_wp_q       <= a_wp_d;
            a_rp_q       <= a_rp_d;
            a_cnt_q      <= a_cnt_d;
            a_af_q       <= a_af_d;
            b_wp_q       <= b_wp_d;
            b_rp_q       <= b_rp_d;
            b_cnt_q      <= b_cnt_d;
            b_af_q       <= b_af_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < ENGINE_NUM; e++)
            if (a_push[e]) a_mem[e][a_wp_q[e]] <= dispatch_axb_a_data[512*e +: 512];
        if (b_push) b_mem[b_wp_q] <= dispatch_axb_b_data;
    end

`ifdef SGD_STATE_COUNTERS_EN
    logic [63:0] apop_q, apop_d;
    logic [31:0] bpop_q, bpop_d, stall_q, stall_d;
    logic [7:0]  ovf_q, ovf_d;
    logic        stall;

    // Stall: any open quota whose FIFO has nothing to offer this cycle
    always_comb begin
        stall  = (b_used_q < qb_q) && (b_cnt_q == 5'd0);
        ovf_d  = ovf_q;
        for (int e = 0; e < ENGINE_NUM; e++)
            if (a_used_q[e] < qa_q && a_cnt_q[e] == 7'd0) stall = 1'b1;
        for (int e = 0; e < ENGINE_NUM && e < 8; e++)
            if (dispatch_axb_a_wr_en[e] && a_cnt_q[e] == 7'd64) ovf_d[e] = 1'b1;
        apop_d  = apop_q + 64'(a_pop[0]);
        bpop_d  = bpop_q + 32'(b_pop);
        stall_d = stall_q + 32'((state_q == S_RUN) && stall);
        if (run_start) begin
            apop_d  = '0;
            bpop_d  = '0;
            stall_d = '0;
            ovf_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apop_q  <= '0;
            bpop_q  <= '0;
            stall_q <= '0;
            ovf_q   <= '0;
        end else begin
            apop_q  <= apop_d;
            bpop_q  <= bpop_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    assign um_state_counters = {88'd0, ovf_q, stall_q, bpop_q, apop_q, epoch_q};
`else
    assign um_state_counters = '0;
`endif

    assign um_done                    = um_done_q;
    assign dispatch_axb_a_almost_full = a_af_q;
    assign dispatch_axb_b_almost_full = b_af_q;
    assign x_data_send_back_start     = start_q;
    assign x_data_send_back_addr      = wb_addr_q;
    assign x_data_send_back_length    = wb_len_q;
    assign x_data_out                 = data_q;
    assign x_data_out_valid           = valid_q;
endmodule

// File: tb/tb_sgd_top_bw_core.sv
// Directed bench for sgd_top_bw_core with a write-back scoreboard (single-engine default build).
module tb_sgd_top_bw_core;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_um;
    logic [63:0]  addr_model;
    logic [31:0]  mini_batch_size, step_size, number_of_epochs, dimension, number_of_samples, number_of_bits;
    logic         um_done;
    logic [255:0] um_state_counters;
    logic [511:0] a_data;
    logic [0:0]   a_wr;
    logic [0:0]   a_af;
    logic [255:0] b_data;
    logic         b_wr, b_af;
    logic         wb_start;
    logic [63:0]  wb_addr;
    logic [31:0]  wb_len;
    logic [511:0] x_out;
    logic         x_valid, x_af;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    logic [63:0]  exp_addr_q [$];
    logic [31:0]  exp_len_q  [$];
    logic [511:0] exp_word_q [$];

    sgd_top_bw_core dut (
        .clk(clk), .rst_n(rst_n), .start_um(start_um), .addr_model(addr_model),
        .mini_batch_size(mini_batch_size), .step_size(step_size),
        .number_of_epochs(number_of_epochs), .dimension(dimension),
        .number_of_samples(number_of_samples), .number_of_bits(number_of_bits),
        .um_done(um_done), .um_state_counters(um_state_counters),
        .dispatch_axb_a_data(a_data), .dispatch_axb_a_wr_en(a_wr), .dispatch_axb_a_almost_full(a_af),
        .dispatch_axb_b_data(b_data), .dispatch_axb_b_wr_en(b_wr), .dispatch_axb_b_almost_full(b_af),
        .x_data_send_back_start(wb_start), .x_data_send_back_addr(wb_addr),
        .x_data_send_back_length(wb_len), .x_data_out(x_out), .x_data_out_valid(x_valid),
        .x_data_out_almost_full(x_af)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] a_word(input int n);
        logic [511:0] w;
        for (int j = 0; j < 16; j++) w[32*j +: 32] = 32'(n * 16 + j + 1);
        return w;
    endfunction

    function automatic logic [255:0] b_word(input int n);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'(1000 + n * 8 + k);
        return w;
    endfunction

    function automatic logic [511:0] a_sum(input int first, input int cnt);
        logic [511:0] s, w;
        s = '0;
        for (int i = 0; i < cnt; i++) begin
            w = a_word(first + i);
            for (int j = 0; j < 16; j++) s[32*j +: 32] = s[32*j +: 32] + w[32*j +: 32];
        end
        return s;
    endfunction

    function automatic logic [511:0] b_sum(input int first, input int cnt);
        logic [255:0] s, w;
        s = '0;
        for (int i = 0; i < cnt; i++) begin
            w = b_word(first + i);
            for (int k = 0; k < 8; k++) s[32*k +: 32] = s[32*k +: 32] + w[32*k +: 32];
        end
        return {256'd0, s};
    endfunction

    task automatic push_a(input logic [511:0] w);
        a_wr = 1'b1; a_data = w; @(negedge clk); a_wr = 1'b0;
    endtask

    task automatic push_b(input logic [255:0] w);
        b_wr = 1'b1; b_data = w; @(negedge clk); b_wr = 1'b0;
    endtask

    task automatic expect_epoch(input logic [63:0] addr, input logic [511:0] w0, input logic [511:0] w1);
        exp_addr_q.push_back(addr);
        exp_len_q.push_back(32'd128);
        exp_word_q.push_back(w0);
        exp_word_q.push_back(w1);
    endtask

    task automatic pulse_start();
        start_um = 1'b1; @(negedge clk); start_um = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!um_done && i < budget) begin @(negedge clk); i++; end
        chk(tag, 512'(um_done), 512'd1);
    endtask

    task automatic wait_wb_start(input string tag, input int budget);
        int i = 0;
        while (!wb_start && i < budget) begin @(negedge clk); i++; end
        chk(tag, 512'(wb_start), 512'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_start) begin
                n_starts++;
                chk("start_expected", 512'(exp_addr_q.size() != 0), 512'd1);
                if (exp_addr_q.size() != 0) begin
                    chk("wb_addr", 512'(wb_addr), 512'(exp_addr_q.pop_front()));
                    chk("wb_len", 512'(wb_len), 512'(exp_len_q.pop_front()));
                end
            end
            if (x_valid) begin
                chk("word_expected", 512'(exp_word_q.size() != 0), 512'd1);
                if (exp_word_q.size() != 0) chk("wb_word", x_out, exp_word_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic af_seen;
        logic [511:0] hold_word;
        rst_n = 1'b0; start_um = 1'b0; addr_model = '0; mini_batch_size = 32'd8; step_size = 32'd3;
        number_of_epochs = 32'd1; dimension = 32'd64; number_of_samples = 32'd16; number_of_bits = 32'd2;
        a_wr = 1'b1; a_data = '1; b_wr = 1'b1; b_data = '1; x_af = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 512'(x_valid), 512'd0);
        chk("rst_start", 512'(wb_start), 512'd0);
        chk("rst_done", 512'(um_done), 512'd0);
        chk("rst_af_a", 512'(a_af), 512'd0);
        chk("rst_af_b", 512'(b_af), 512'd0);
        chk("rst_data", x_out, 512'd0);
        chk("rst_addr_len", {wb_addr, wb_len}, 512'd0);
        chk("rst_counters", 512'(um_state_counters), 512'd0);
        a_wr = 1'b0; b_wr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_af_a", 512'(a_af), 512'd0);

        // Basic single epoch: Qa=4, Qb=2
        addr_model = 64'h1000_0000;
        repeat (4) push_a({16{32'h1}});
        repeat (2) push_b({8{32'd2}});
        expect_epoch(64'h1000_0000, {16{32'd4}}, {256'd0, {8{32'd4}}});
        pulse_start();
        wait_done("basic_done", 100);
        chk("basic_starts", 512'(n_starts), 512'd1);

        // Three epochs with write-back back-pressure in the first one
        addr_model = 64'h2000; number_of_epochs = 32'd3;
        for (int i = 0; i < 12; i++) push_a(a_word(i));
        for (int i = 0; i < 6; i++) push_b(b_word(i));
        for (int e = 0; e < 3; e++)
            expect_epoch(64'h2000 + 64'(e * 128), a_sum(4 * e, 4), b_sum(2 * e, 2));
        pulse_start();
        wait_wb_start("ep3_first_start", 100);
        @(negedge clk);
        chk("hold_first_valid", 512'(x_valid), 512'd1);
        hold_word = a_sum(0, 4);
        x_af = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_no_valid", 512'(x_valid), 512'd0);
            chk("hold_data", x_out, hold_word);
        end
        x_af = 1'b0;
        wait_done("ep3_done", 200);
        chk("ep3_starts", 512'(n_starts), 512'd4);

        // Zero epochs: done quickly, no write-back
        number_of_epochs = 32'd0;
        start_um = 1'b1;
        @(negedge clk);
        start_um = 1'b0;
        chk("ep0_done_clear", 512'(um_done), 512'd0);
        wait_done("ep0_done", 3);
        repeat (5) @(negedge clk);
        chk("ep0_starts", 512'(n_starts), 512'd4);

        // Flood A while B is empty
        addr_model = 64'h3000; number_of_epochs = 32'd1;
        pulse_start();
        repeat (10) @(negedge clk);
        n = 0; af_seen = 1'b0;
        for (int i = 0; i < 70 && !af_seen; i++) begin
            a_wr = 1'b1; a_data = a_word(100 + i);
            @(negedge clk);
            n++;
            af_seen = a_af[0];
        end
        a_wr = 1'b0;
        chk("flood_af_at_push", 512'(n), 512'd60);
        chk("flood_blocked", 512'(um_done), 512'd0);
`ifdef SGD_STATE_COUNTERS_EN
        chk("flood_no_overflow", 512'(um_state_counters[167:160]), 512'd0);
        chk("flood_a_popped", 512'(um_state_counters[95:32]), 512'd4);
`else
        chk("counters_tied_zero", 512'(um_state_counters), 512'd0);
`endif
        expect_epoch(64'h3000, a_sum(100, 4), b_sum(20, 2));
        push_b(b_word(20));
        push_b(b_word(21));
        wait_done("flood_done", 100);
        chk("flood_starts", 512'(n_starts), 512'd5);

        // Reset mid-run aborts without write-back and empties the FIFOs
        pulse_start();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_done", 512'(um_done), 512'd0);
        chk("midrst_valid", 512'(x_valid), 512'd0);
        chk("midrst_addr", 512'(wb_addr), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_starts", 512'(n_starts), 512'd5);

        addr_model = 64'h4000;
        repeat (4) push_a({16{32'h1}});
        repeat (2) push_b({8{32'd2}});
        expect_epoch(64'h4000, {16{32'd4}}, {256'd0, {8{32'd4}}});
        pulse_start();
        wait_done("after_rst_done", 100);
        repeat (3) @(negedge clk);
        chk("final_starts", 512'(n_starts), 512'd6);
        chk("sb_addr_empty", 512'(exp_addr_q.size()), 512'd0);
        chk("sb_word_empty", 512'(exp_word_q.size()), 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sgd_top_bw_core.md
# sgd_top_bw_core

Bandwidth-characterisation top of the distributed SGD accelerator: accepts bit-plane-packed sample data (A) per engine and label data (B) from the dispatch layer, consumes exactly one epoch's worth of words per epoch, and folds them into lane-wise checksums. At each epoch end it writes the checksums back through the memory write interface. It sits between the HBM/DMA dispatcher and the model write-back path; no model arithmetic is performed.

## Interface
Parameters:
- DATA_WIDTH_IN, 4: reserved; no effect.
- MAX_DIMENSION_BITS, 18: `dimension` must be < 2^MAX_DIMENSION_BITS; larger values are clamped to 2^MAX_DIMENSION_BITS−1.
- SLR0_ENGINE_NUM / SLR1_ENGINE_NUM / SLR2_ENGINE_NUM, 0/1/0: ENGINE_NUM = sum; must equal the `ENGINE_NUM` define.

Ports (`NUM_OF_BANKS`=8, `NUM_BITS_PER_BANK`=64):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: single clock for the whole block.
  - rst_n, in, 1: asynchronous, active-low reset.
- Control:
  - start_um, in, 1: rising edge starts a run.
  - addr_model, in, 64: write-back base byte address.
  - mini_batch_size, step_size, in, 32 each: latched at start; unused.
  - number_of_epochs, dimension, number_of_samples, number_of_bits, in, 32 each.
  - um_done, out, 1: run complete.
  - um_state_counters, out, 256: status.
- A input:
  - dispatch_axb_a_data, in, ENGINE_NUM×512.
  - dispatch_axb_a_wr_en, in, ENGINE_NUM.
  - dispatch_axb_a_almost_full, out, ENGINE_NUM.
- B input:
  - dispatch_axb_b_data, in, 256.
  - dispatch_axb_b_wr_en, in, 1.
  - dispatch_axb_b_almost_full, out, 1.
- Write-back:
  - x_data_send_back_start, out, 1.
  - x_data_send_back_addr, out, 64.
  - x_data_send_back_length, out, 32.
  - x_data_out, out, 512.
  - x_data_out_valid, out, 1.
  - x_data_out_almost_full, in, 1.

## Operation
- FIFOs:
  - Per-engine A FIFO: depth 64; almost_full when count ≥ 56.
  - B FIFO: depth 16; almost_full when count ≥ 12.
  - A write while full is dropped and sets sticky overflow bit.
- States:
  - IDLE → LOAD on start_um rising edge. Latch all config; clear um_done, epoch counter, and counters.
  - LOAD:
    - A quota Qa = ((samples>>3)·(dimension>>6)·bits) / ENGINE_NUM, division by iterative subtraction, remainder discarded.
    - B quota Qb = samples>>3.
    - If epochs=0 → DONE, else → RUN.
  - RUN:
    - Each engine independently pops one A word per cycle when its FIFO is non-empty and its consumed count < Qa.
    - B pops one word per cycle when non-empty and its count < Qb.
    - Accumulators update on every pop:
      - A lane j (0..15) += word[32j+:32].
      - B lane k (0..7) += word[32k+:32].
      - All sums mod 2^32.
    - When all quotas are met (including Qa=0 or Qb=0) → WB.
  - WB:
    - One-cycle pulse x_data_send_back_start, with:
      - addr = addr_model + epoch·(ENGINE_NUM+1)·64.
      - length = (ENGINE_NUM+1)·64.
    - Then emits words engine 0..ENGINE_NUM−1 (A lane sums), then one B word (lanes 0..7, upper 256 bits zero).
    - One word per cycle, only while x_data_out_almost_full=0.
    - After the last word: clear accumulators and quota counts; epoch+1. If epoch = number_of_epochs → DONE, else → RUN.
  - DONE: um_done=1; held until the next start_um rising edge (→ LOAD).
- FIFO contents persist across epochs; surplus words wait for the next epoch.
- start_um edges outside IDLE/DONE are ignored.

## Timing
- Reset values: all outputs 0. FIFOs empty; almost_full=0.
- Async reset mid-run aborts immediately. No write-back is emitted.
- almost_full is registered and reflects the count after the current cycle's push/pop (1-cycle delay).
- FIFO write-to-pop latency: 1 cycle (first-word-fall-through).
- Push and pop in the same cycle: count unchanged.
- start pulse to first x_data_out_valid: 1 cycle, if not back-pressured.
- x_data_out_almost_full asserted: valid drops the next cycle; the word is held.

## Configuration
- SGD_STATE_COUNTERS_EN defined:
  - um_state_counters = {overflow bits[7:0], stall cycles in RUN with any quota open and its FIFO empty[31:0], B words popped total[31:0], A words popped engine 0 total[63:0], epochs completed[31:0], zero pad}.
  - Field order LSB-first: epochs[31:0], A[95:32], B[127:96], stalls[159:128], overflow[167:160].
- Undefined: um_state_counters tied to 0; counter logic absent.

## Test plan
- Reset with rst_n=0, wr_en held: all outputs 0, almost_full 0, nothing stored.
- ENGINE_NUM=1, samples=16, dimension=64, bits=2, epochs=1; A words all 32'h1 lanes, B lane value 2:
  - Qa=4, Qb=2.
  - Exactly one write-back: addr=addr_model, length=128.
  - Word0 lanes=4; word1 lanes0..7=4, upper zero; um_done=1.
- epochs=3, same config: 3 start pulses at addr_model, +128, +256; accumulators restart at 0 each epoch.
- Flood A continuously while RUN is blocked on B: almost_full at count 56, no overflow bit set; release B → completes.
- Hold x_data_out_almost_full=1 for 10 cycles during WB: no valid; data unchanged on resume.
- epochs=0: um_done within 3 cycles of start, no x_data_send_back_start.
